seq_code_lock: RTL and testbench
================================

// Module: seq_code_lock
// PURPOSE
//  Parametrised switch-entered combination lock for the board top level.
//  Operator sets SW and presses KEY[1] (enter) once per code step; KEY[0] clears or relocks.
//  Adds a wrong-entry counter with timed lockout, and a code-reprogram mode reachable only
//  while unlocked. Drives the LED bank with progress, unlock, lockout and programming status.
// PARAMETERS
//  SW_W        4              width of one code step (switch count)
//  STEPS       3              code length in steps; legal range 1..LED_W-2
//  CODE        12'h110        reset code, flattened; step i = CODE[i*SW_W +: SW_W] (default 0,1,1)
//  MAX_FAIL    3              consecutive wrong steps that trigger lockout; >=1
//  LOCKOUT_CYC 50_000_000     lockout duration in clk cycles (1 s at 50 MHz); >=1
//  LED_W       8              LED bank width; >= STEPS+2
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous, active-high reset
//  KEY        in   2            push buttons, active-low, asynchronous: [1]=enter, [0]=clear
//  SW         in   SW_W         code switches, treated as quasi-static, sampled on enter press
//  LED        out  LED_W        status display, registered
//  unlocked   out  1            high while in UNLOCKED, registered
//  locked_out out  1            high while in LOCKOUT, registered
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, fail_cnt=0, timer=0, code_reg=CODE, shadow=CODE,
//   LED=0, unlocked=0, locked_out=0, key sync/edge regs=2'b11 (released).
//  Keys: 2-flop synchroniser, then edge register; press pulse = prev high & now low, 1 cycle.
//   A KEY fall sampled at edge n gives state/output update at edge n+2. Held key = one press.
//  IDLE: one cycle, LED=0, then ENTRY with idx=0.
//  ENTRY (idx = matched steps): LED = thermometer of idx in LED[STEPS-1:0], upper bits 0.
//   enter & SW==code_reg[idx]: idx+1; if idx==STEPS-1 -> UNLOCKED, fail_cnt=0.
//   enter & mismatch: idx=0, fail_cnt+1; if fail_cnt+1==MAX_FAIL -> LOCKOUT,
//   timer=LOCKOUT_CYC-1, fail_cnt=0.
//   clear: idx=0, fail_cnt unchanged. clear+enter same cycle: clear wins, enter dropped.
//  UNLOCKED: LED=all ones, unlocked=1. enter alone ignored. clear alone -> ENTRY idx=0.
//   enter+clear same cycle -> PROG, idx=0, shadow=code_reg.
//  PROG: LED[LED_W-1]=1, LED[LED_W-2]=1, LED[STEPS-1:0]=thermometer of steps stored; unlocked=0.
//   enter: shadow[idx]=SW, idx+1; after step STEPS-1 stored: code_reg=whole shadow
//   (same edge), -> ENTRY idx=0. clear (alone or with enter): abort, code_reg unchanged,
//   -> UNLOCKED.
//  LOCKOUT: locked_out=1, LED={1'b1, zeros}. All presses ignored and discarded.
//   timer decrements each cycle; at timer==0 -> ENTRY idx=0. Presses during the last cycle
//   are discarded.
//  Code compare is full SW_W-bit equality; unused LED bits between STEPS and LED_W-3 are 0
//   in every state.
//  Illegal state encoding: recover to IDLE next cycle.
//  Reset mid-operation (any state, incl. PROG/LOCKOUT): immediate return to reset values;
//   reprogrammed code is lost and CODE is restored.
//  timer width = $clog2(LOCKOUT_CYC+1); fail_cnt width = $clog2(MAX_FAIL+1); no wrap possible.
// STRUCTURE
//  lock_pkg: state encodings (IDLE, ENTRY, UNLOCKED, PROG, LOCKOUT) as localparams, KEY
//   index constants (KEY_ENTER=1, KEY_CLEAR=0).
//  Sub-module key_edge #(W): W-bit 2-flop synchroniser + falling-edge pulse, async rst to 1s.
//  Top: one FSM always block, code_reg/shadow arrays, fail counter, lockout timer, LED decode.
// TESTING (bench uses LOCKOUT_CYC=20, defaults otherwise, press = KEY low 3 cycles)
//  1 Reset, enter SW=0,1,1 -> LED 00000001,00000011, then 11111111 & unlocked=1 two edges
//    after third fall.
//  2 SW=0 then SW=5 -> LED back to 00000000, no lockout; repeat wrong x3 -> locked_out=1,
//    LED=10000000 for exactly 20 cycles, presses ignored, then ENTRY.
//  3 Unlocked, press enter+clear together -> PROG (LED 11000000); store 7,2,9 -> relocked;
//    old 0,1,1 fails; 7,2,9 unlocks.
//  4 In PROG after one stored step press clear -> UNLOCKED, code still 0,1,1.
//  5 Two wrong steps, one clear, one wrong -> lockout (clear does not reset fail_cnt);
//    correct code after lockout resets fail_cnt to 0.
//  6 Assert rst during PROG and during LOCKOUT -> all outputs 0 asynchronously; code = CODE.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encoding and push-button index constants for the code lock.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_PROG     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  localparam int unsigned KEY_ENTER = 1;
  localparam int unsigned KEY_CLEAR = 0;

endpackage

// File: rtl/key_edge.sv
// Synchronises active-low push buttons and emits a one-cycle pulse on each press (falling edge).
module key_edge #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] press
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  // Reset to all-ones so a released (high) key never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

endmodule

// File: rtl/seq_code_lock.sv
// Switch-entered combination lock with wrong-entry lockout and in-field code reprogramming.
module seq_code_lock
  import lock_pkg::*;
#(
  parameter int unsigned               SW_W        = 4,
  parameter int unsigned               STEPS       = 3,
  parameter logic [STEPS*SW_W-1:0]     CODE        = 12'h110,
  parameter int unsigned               MAX_FAIL    = 3,
  parameter int unsigned               LOCKOUT_CYC = 50_000_000,
  parameter int unsigned               LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       KEY,
  input  logic [SW_W-1:0]  SW,
  output logic [LED_W-1:0] LED,
  output logic             unlocked,
  output logic             locked_out
);

  localparam int unsigned IDX_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned TMR_W  = $clog2(LOCKOUT_CYC + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(STEPS - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  typedef logic [STEPS-1:0][SW_W-1:0] code_t;

  logic [1:0]        press;
  logic              enter;
  logic              clear;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  code_t             code_q, code_d;
  code_t             shadow_q, shadow_d;
  logic [SW_W-1:0]   cur_step;
  logic [LED_W-1:0]  led_d;
  logic              unlocked_d;
  logic              locked_out_d;

  key_edge #(.W(2)) u_keys (
    .clk   (clk),
    .rst   (rst),
    .din   (KEY),
    .press (press)
  );

  assign enter = press[KEY_ENTER];
  assign clear = press[KEY_CLEAR];

  function automatic logic [LED_W-1:0] therm(input logic [IDX_W-1:0] n);
    logic [LED_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (IDX_W'(i) < n) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [LED_W-1:0] led_decode(input state_t s, input logic [IDX_W-1:0] n);
    logic [LED_W-1:0] l;
    l = '0;
    case (s)
      ST_ENTRY:    l = therm(n);
      ST_UNLOCKED: l = '1;
      ST_PROG: begin
        l = therm(n);
        l[LED_W-1] = 1'b1;
        l[LED_W-2] = 1'b1;
      end
      ST_LOCKOUT:  l[LED_W-1] = 1'b1;
      default:     l = '0;
    endcase
    return l;
  endfunction

  always_comb begin
    cur_step = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (idx_q == IDX_W'(i)) cur_step = code_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    code_d   = code_q;
    shadow_d = shadow_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
      end

      ST_ENTRY: begin
        if (clear) begin
          idx_d = '0;
        end else if (enter) begin
          if (SW == cur_step) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_UNLOCKED;
              idx_d   = '0;
              fail_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            idx_d = '0;
            if (fail_q + 1'b1 == FAIL_MAX) begin
              state_d = ST_LOCKOUT;
              timer_d = TMR_LOAD;
              fail_d  = '0;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (enter && clear) begin
          state_d  = ST_PROG;
          idx_d    = '0;
          shadow_d = code_q;
        end else if (clear) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end
      end

      ST_PROG: begin
        if (clear) begin
          state_d = ST_UNLOCKED;
          idx_d   = '0;
        end else if (enter) begin
          for (int unsigned i = 0; i < STEPS; i++) begin
            if (idx_q == IDX_W'(i)) shadow_d[i] = SW;
          end
          // Commit includes the step written this same cycle.
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_d;
            state_d = ST_ENTRY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    led_d        = led_decode(state_d, idx_d);
    unlocked_d   = (state_d == ST_UNLOCKED);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      code_q     <= CODE;
      shadow_q   <= CODE;
      LED        <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      LED        <= led_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
    end
  end

endmodule

// File: tb/tb_seq_code_lock.sv
// Self-checking bench for seq_code_lock: vector table, hand sequences, randomized model check.
module tb_seq_code_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic [3:0] SW  = 4'd0;
  logic [7:0] LED;
  logic       unlocked;
  logic       locked_out;

  int checks   = 0;
  int failures = 0;

  seq_code_lock #(.LOCKOUT_CYC(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .KEY        (KEY),
    .SW         (SW),
    .LED        (LED),
    .unlocked   (unlocked),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    bit         cl;
    logic [3:0] sw;
    logic [7:0] led;
    bit         unl;
    bit         lo;
  } vec_t;

  vec_t tbl[$];

  typedef enum int { M_ENTRY, M_UNL, M_PROG, M_LOCK } mode_t;
  mode_t      m_mode;
  int         m_prog;
  int         m_fails;
  logic [3:0] m_code[3];
  logic [3:0] m_shadow[3];

  task automatic chk(input string name, input logic [7:0] el, input bit eu, input bit elo);
    checks++;
    if (LED !== el || unlocked !== eu || locked_out !== elo) begin
      failures++;
      $display("FAIL %s: got LED=%b unlocked=%b locked_out=%b, want LED=%b unlocked=%b locked_out=%b",
               name, LED, unlocked, locked_out, el, eu, elo);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Hold the selected keys low for 3 cycles, release, let the result settle.
  task automatic do_press(input bit en, input bit cl, input logic [3:0] s);
    SW = s;
    @(negedge clk);
    KEY = {~en, ~cl};
    repeat (3) @(negedge clk);
    KEY = 2'b11;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_lockout_end(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!locked_out) begin
        done = 1;
        break;
      end
    end
    chk_int({name, "_lockout_ends"}, int'(done), 1);
    @(negedge clk);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk({name, "_async"}, 8'h00, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] therm(input int n);
    logic [7:0] t;
    t = 8'd0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic logic [7:0] m_led();
    case (m_mode)
      M_ENTRY: return therm(m_prog);
      M_UNL:   return 8'hFF;
      M_PROG:  return 8'hC0 | therm(m_prog);
      default: return 8'h80;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = M_ENTRY;
    m_prog  = 0;
    m_fails = 0;
    m_code[0] = 4'd0; m_code[1] = 4'd1; m_code[2] = 4'd1;
  endtask

  task automatic model_press(input bit en, input bit cl, input logic [3:0] s);
    case (m_mode)
      M_ENTRY: begin
        if (cl) m_prog = 0;
        else if (en) begin
          if (s == m_code[m_prog]) begin
            m_prog++;
            if (m_prog == 3) begin m_mode = M_UNL; m_prog = 0; m_fails = 0; end
          end else begin
            m_prog = 0;
            m_fails++;
            if (m_fails == 3) begin m_mode = M_LOCK; m_fails = 0; end
          end
        end
      end
      M_UNL: begin
        if (en && cl) begin
          m_mode = M_PROG; m_prog = 0;
          for (int i = 0; i < 3; i++) m_shadow[i] = m_code[i];
        end else if (cl) begin
          m_mode = M_ENTRY; m_prog = 0;
        end
      end
      M_PROG: begin
        if (cl) m_mode = M_UNL;
        else if (en) begin
          m_shadow[m_prog] = s;
          m_prog++;
          if (m_prog == 3) begin
            for (int i = 0; i < 3; i++) m_code[i] = m_shadow[i];
            m_mode = M_ENTRY; m_prog = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic vec_t mk(bit en, bit cl, logic [3:0] sw, logic [7:0] led, bit unl, bit lo);
    vec_t v;
    v.en = en; v.cl = cl; v.sw = sw; v.led = led; v.unl = unl; v.lo = lo;
    return v;
  endfunction

  initial begin
    int cnt;
    int bad_led;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_hold", 8'h00, 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_reset", 8'h00, 0, 0);

    // Unlock latency: outputs change two edges after the sampled third fall
    do_press(1, 0, 4'd0);
    chk("t1_step1", 8'h01, 0, 0);
    do_press(1, 0, 4'd1);
    chk("t1_step2", 8'h03, 0, 0);
    SW = 4'd1;
    @(negedge clk);
    KEY = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_edge_n1", 8'h03, 0, 0);
    @(posedge clk); #1;
    chk("t1_edge_n2", 8'hFF, 1, 0);
    repeat (2) @(negedge clk);
    KEY = 2'b11;
    repeat (3) @(negedge clk);

    // Vector table continuing from UNLOCKED with the reset code
    tbl.push_back(mk(1, 0, 4'd5, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 1, 4'd0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 4'd0, 8'h01, 0, 0));
    tbl.push_back(mk(1, 0, 4'd5, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 4'd0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 4'd0, 8'h01, 0, 0));
    tbl.push_back(mk(1, 0, 4'd1, 8'h03, 0, 0));
    tbl.push_back(mk(1, 0, 4'd1, 8'hFF, 1, 0));
    tbl.push_back(mk(1, 1, 4'd0, 8'hC0, 0, 0));
    tbl.push_back(mk(1, 0, 4'd7, 8'hC1, 0, 0));
    tbl.push_back(mk(1, 0, 4'd2, 8'hC3, 0, 0));
    tbl.push_back(mk(1, 0, 4'd9, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 4'd0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 4'd7, 8'h01, 0, 0));
    tbl.push_back(mk(1, 0, 4'd2, 8'h03, 0, 0));
    tbl.push_back(mk(1, 0, 4'd9, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 1, 4'd0, 8'h00, 0, 0));
    foreach (tbl[i]) begin
      do_press(tbl[i].en, tbl[i].cl, tbl[i].sw);
      chk($sformatf("vec%0d", i), tbl[i].led, tbl[i].unl, tbl[i].lo);
    end

    // Lockout: exact duration, presses ignored, then back to entry
    async_reset("pre_lock");
    do_press(1, 0, 4'd0);
    do_press(1, 0, 4'd5);
    chk("t2_wrong1", 8'h00, 0, 0);
    do_press(1, 0, 4'd5);
    chk("t2_wrong2", 8'h00, 0, 0);
    SW = 4'd5;
    @(negedge clk);
    KEY = 2'b01;
    cnt = 0;
    bad_led = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 3)  KEY = 2'b11;
      if (i == 6)  KEY = 2'b00;
      if (i == 9)  KEY = 2'b11;
      if (i == 12) begin SW = 4'd0; KEY = 2'b01; end
      if (i == 15) KEY = 2'b11;
      if (locked_out) begin
        cnt++;
        if (LED !== 8'h80) bad_led++;
      end
    end
    chk_int("t2_lock_cycles", cnt, 20);
    chk_int("t2_lock_led_bad", bad_led, 0);
    chk("t2_after_lock", 8'h00, 0, 0);

    // Abort programming after one stored step keeps the old code
    async_reset("t4");
    do_press(1, 0, 4'd0); do_press(1, 0, 4'd1); do_press(1, 0, 4'd1);
    do_press(1, 1, 4'd0);
    do_press(1, 0, 4'd6);
    chk("t4_prog1", 8'hC1, 0, 0);
    do_press(0, 1, 4'd0);
    chk("t4_abort", 8'hFF, 1, 0);
    do_press(0, 1, 4'd0);
    do_press(1, 0, 4'd0); do_press(1, 0, 4'd1); do_press(1, 0, 4'd1);
    chk("t4_oldcode", 8'hFF, 1, 0);

    // Clear does not reset the failure count; unlocking does
    async_reset("t5");
    do_press(1, 0, 4'd9); do_press(1, 0, 4'd9);
    do_press(0, 1, 4'd0);
    do_press(1, 0, 4'd9);
    chk("t5_locked", 8'h80, 0, 1);
    wait_lockout_end("t5");
    do_press(1, 0, 4'd9);
    do_press(1, 0, 4'd0); do_press(1, 0, 4'd1); do_press(1, 0, 4'd1);
    chk("t5_unlock", 8'hFF, 1, 0);
    do_press(0, 1, 4'd0);
    do_press(1, 0, 4'd9); do_press(1, 0, 4'd9);
    chk("t5_cnt_cleared", 8'h00, 0, 0);

    // Reset during PROG discards a reprogrammed code
    async_reset("t6a_pre");
    do_press(1, 0, 4'd0); do_press(1, 0, 4'd1); do_press(1, 0, 4'd1);
    do_press(1, 1, 4'd0);
    do_press(1, 0, 4'd7); do_press(1, 0, 4'd2); do_press(1, 0, 4'd9);
    do_press(1, 0, 4'd7); do_press(1, 0, 4'd2); do_press(1, 0, 4'd9);
    chk("t6_newcode", 8'hFF, 1, 0);
    do_press(1, 1, 4'd0);
    do_press(1, 0, 4'd3);
    chk("t6_in_prog", 8'hC1, 0, 0);
    async_reset("t6_prog");
    do_press(1, 0, 4'd0); do_press(1, 0, 4'd1); do_press(1, 0, 4'd1);
    chk("t6_code_restored", 8'hFF, 1, 0);

    // Reset during LOCKOUT
    do_press(0, 1, 4'd0);
    do_press(1, 0, 4'd8); do_press(1, 0, 4'd8); do_press(1, 0, 4'd8);
    chk("t6_locked", 8'h80, 0, 1);
    async_reset("t6_lock");
    do_press(1, 0, 4'd0);
    chk("t6_after_lock_rst", 8'h01, 0, 0);

    // Randomized presses against the behavioural model
    async_reset("rnd");
    model_reset();
    for (int n = 0; n < 200; n++) begin
      int r;
      bit en, cl;
      logic [3:0] s;
      r  = $urandom_range(0, 9);
      en = (r <= 5) || (r >= 8);
      cl = (r >= 6);
      if (m_mode == M_ENTRY && $urandom_range(0, 3) != 0) s = m_code[m_prog];
      else s = 4'($urandom_range(0, 15));
      do_press(en, cl, s);
      model_press(en, cl, s);
      chk($sformatf("rnd%0d", n), m_led(), m_mode == M_UNL, m_mode == M_LOCK);
      if (m_mode == M_LOCK) begin
        wait_lockout_end($sformatf("rnd%0d", n));
        m_mode = M_ENTRY;
        m_prog = 0;
        chk($sformatf("rnd%0d_exit", n), m_led(), 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
